// File: rtl/dmem_arbiter.sv
// Two-way arbiter sharing the single-port data memory between the CPU load/store
// port and the loader/debug port; CPU-first with starvation and burst bounds.
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 3,
   parameter int MAX_BURST    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   input  logic              ldr_halt,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              gnt_ldr
);

   localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   typedef enum logic {
      CPU_PRI = 1'b0,
      LDR_PRI = 1'b1
   } pri_t;

   pri_t          pri;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] burst_cnt;
   logic [BW-1:0] burst_inc;
   logic          gnt_l;
   logic          gnt_c;

   assign burst_inc = burst_cnt + 1'b1;

   // Handshake: a requester holds req (and its addr/data/we) until it sees
   // completion; CPU completes in any cycle with cpu_req & !cpu_stall, the
   // loader in any cycle with ldr_ack. Each completion is exactly one access.
   always_comb begin
      gnt_l = 1'b0;
      gnt_c = 1'b0;
      if (!reset) begin
         gnt_l = 1'b0;
         gnt_c = 1'b0;
      end else if (ldr_halt) begin
         gnt_l = ldr_req;
         gnt_c = 1'b0;
      end else if (pri == LDR_PRI) begin
         gnt_l = ldr_req;
         gnt_c = cpu_req & ~ldr_req;
      end else begin
         gnt_l = ldr_req & (~cpu_req | (wait_cnt == WAIT_MAX));
         gnt_c = cpu_req & ~gnt_l;
      end
   end

   // Idle cycles park the mux on the CPU side so its address stays stable.
   always_comb begin
      mem_addr  = gnt_l ? ldr_addr  : cpu_addr;
      mem_wdata = gnt_l ? ldr_wdata : cpu_wdata;
      mem_we    = (gnt_l & ldr_we) | (gnt_c & cpu_we);
   end

   assign cpu_rdata = mem_rdata;
   assign ldr_rdata = mem_rdata;
   assign cpu_stall = cpu_req & ~gnt_c;
   assign ldr_ack   = gnt_l;
   assign gnt_ldr   = gnt_l;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pri       <= CPU_PRI;
         wait_cnt  <= '0;
         burst_cnt <= '0;
      end else begin
         if (ldr_halt) begin
            wait_cnt <= '0;
         end else if (ldr_req && !gnt_l) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end

         // Halt freezes the priority window so arbitration resumes where it left off.
         if (!ldr_halt) begin
            if (gnt_l) begin
               if (burst_inc == BURST_MAX) begin
                  pri       <= CPU_PRI;
                  burst_cnt <= '0;
               end else begin
                  pri       <= LDR_PRI;
                  burst_cnt <= burst_inc;
               end
            end else if (pri == LDR_PRI && !ldr_req) begin
               pri       <= CPU_PRI;
               burst_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port dmem model.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        ldr_req;
   logic        ldr_we;
   logic [31:0] ldr_addr;
   logic [31:0] ldr_wdata;
   logic        ldr_halt;
   logic        ldr_ack;
   logic [31:0] ldr_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        gnt_ldr;

   int n_cmp;
   int n_err;

   logic [31:0] mem [0:63];

   dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3), .MAX_BURST(2)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_halt(ldr_halt), .ldr_ack(ldr_ack),
      .ldr_rdata(ldr_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gnt_ldr(gnt_ldr)
   );

   // Clock and memory model: combinational read, write on posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after posedge; outputs sampled at the following negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #4;
   endtask

   task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      cpu_req   = req;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   task automatic ldr_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      ldr_req   = req;
      ldr_we    = we;
      ldr_addr  = addr;
      ldr_wdata = wdata;
   endtask

   logic [13:0] pat;

   initial begin
      n_cmp = 0;
      n_err = 0;
      ldr_halt = 1'b0;

      // Reset holds outputs quiet regardless of requests.
      reset = 1'b0;
      cpu_drive(1'b1, 1'b0, 32'h0, 32'h0);
      ldr_drive(1'b1, 1'b1, 32'h40, 32'h1111_1111);
      #3;
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_cpu_stall", {31'b0, cpu_stall}, 32'd1);
      check("rst_ldr_ack", {31'b0, ldr_ack}, 32'd0);
      check("rst_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      next_cycle();
      next_cycle();
      sample();
      check("rst_hold_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_hold_ldr_ack", {31'b0, ldr_ack}, 32'd0);

      // First cycle after release: CPU wins with both requesting.
      next_cycle();
      reset = 1'b1;
      sample();
      check("post_rst_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      check("post_rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);

      // CPU-only write then read back.
      next_cycle();
      ldr_drive(1'b0, 1'b0, 32'h0, 32'h0);
      cpu_drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      sample();
      check("cpu_wr_mem_we", {31'b0, mem_we}, 32'd1);
      check("cpu_wr_stall", {31'b0, cpu_stall}, 32'd0);
      check("cpu_wr_addr", mem_addr, 32'h10);
      check("cpu_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      next_cycle();
      cpu_drive(1'b1, 1'b0, 32'h10, 32'h0);
      sample();
      check("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
      check("cpu_rd_ldr_ack", {31'b0, ldr_ack}, 32'd0);
      check("cpu_rd_mem_we", {31'b0, mem_we}, 32'd0);

      // Contention: C,C,C,L,L,C,C,C,L,L then C,C,C,L (lsb first).
      pat = 14'b10_0011_0001_1000;
      for (int i = 0; i < 14; i++) begin
         next_cycle();
         cpu_drive(1'b1, 1'b0, 32'h10, 32'h0);
         ldr_drive(1'b1, 1'b0, 32'h10, 32'h0);
         sample();
         check($sformatf("cont_gnt_%0d", i), {31'b0, gnt_ldr}, {31'b0, pat[i]});
         check($sformatf("cont_stall_%0d", i), {31'b0, cpu_stall}, {31'b0, pat[i]});
         check($sformatf("cont_ack_%0d", i), {31'b0, ldr_ack}, {31'b0, pat[i]});
      end

      // Loader drops out mid-window: CPU takes the slot and priority reverts.
      next_cycle();
      ldr_drive(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check("abort_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      check("abort_cpu_stall", {31'b0, cpu_stall}, 32'd0);
      next_cycle();
      ldr_drive(1'b1, 1'b0, 32'h10, 32'h0);
      sample();
      check("abort_next_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      check("abort_next_stall", {31'b0, cpu_stall}, 32'd0);

      // Halt: loader owns memory, CPU stalled throughout.
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         ldr_halt = 1'b1;
         ldr_drive(1'b1, 1'b1, 32'(k * 4), 32'(k + 1));
         sample();
         check($sformatf("halt_ack_%0d", k), {31'b0, ldr_ack}, 32'd1);
         check($sformatf("halt_stall_%0d", k), {31'b0, cpu_stall}, 32'd1);
         check($sformatf("halt_we_%0d", k), {31'b0, mem_we}, 32'd1);
      end
      next_cycle();
      ldr_drive(1'b1, 1'b0, 32'h04, 32'h0);
      sample();
      check("halt_peek_ack", {31'b0, ldr_ack}, 32'd1);
      check("halt_peek_data", ldr_rdata, 32'h2);
      next_cycle();
      ldr_drive(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check("halt_idle_we", {31'b0, mem_we}, 32'd0);
      check("halt_idle_stall", {31'b0, cpu_stall}, 32'd1);
      check("halt_idle_ack", {31'b0, ldr_ack}, 32'd0);
      next_cycle();
      ldr_halt = 1'b0;
      cpu_drive(1'b1, 1'b0, 32'h08, 32'h0);
      sample();
      check("unhalt_stall", {31'b0, cpu_stall}, 32'd0);
      check("unhalt_rdata", cpu_rdata, 32'h3);

      // Async reset mid-burst: the in-flight loader write must be dropped.
      next_cycle();
      cpu_drive(1'b1, 1'b1, 32'h20, 32'h0000_A5A5);
      sample();
      check("pre_seed_we", {31'b0, mem_we}, 32'd1);
      next_cycle();
      cpu_drive(1'b0, 1'b0, 32'h20, 32'h0);
      ldr_drive(1'b1, 1'b1, 32'h24, 32'h0000_0077);
      sample();
      check("burst1_gnt_ldr", {31'b0, gnt_ldr}, 32'd1);
      next_cycle();
      ldr_drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
      sample();
      check("burst2_gnt_ldr", {31'b0, gnt_ldr}, 32'd1);
      check("burst2_mem_we", {31'b0, mem_we}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("areset_mem_we", {31'b0, mem_we}, 32'd0);
      check("areset_ldr_ack", {31'b0, ldr_ack}, 32'd0);
      check("areset_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      next_cycle();
      cpu_drive(1'b1, 1'b0, 32'h20, 32'h0);
      ldr_drive(1'b1, 1'b0, 32'h24, 32'h0);
      reset = 1'b1;
      sample();
      check("areset_pri_gnt_ldr", {31'b0, gnt_ldr}, 32'd0);
      check("areset_cpu_stall", {31'b0, cpu_stall}, 32'd0);
      check("areset_mem_kept", cpu_rdata, 32'h0000_A5A5);
      next_cycle();
      cpu_drive(1'b1, 1'b0, 32'h24, 32'h0);
      sample();
      check("burst1_write_kept", cpu_rdata, 32'h0000_0077);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
